// File: rtl/vending_input_conditioner.sv
// rtl/vending_input_conditioner.sv - synchronize, debounce and priority-arbitrate the three vending panel inputs
module vending_input_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_coin_raw,
    input  logic i_coffee_raw,
    input  logic i_sprite_raw,
    output logic o_coin,
    output logic o_coffee,
    output logic o_sprite
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel index 0 = coin, 1 = coffee, 2 = sprite; lower index wins arbitration.
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    db_state_t        state    [3];
    db_state_t        state_nx [3];
    logic [CNT_W-1:0] cnt      [3];
    logic [CNT_W-1:0] cnt_nx   [3];
    logic [2:0]       press_acc;
    logic [2:0]       pending;
    logic [2:0]       pend_nx;
    logic [2:0]       grant;

    assign raw = {i_sprite_raw, i_coffee_raw, i_coin_raw};

    always_comb begin
        press_acc = '0;
        for (int i = 0; i < 3; i++) begin
            state_nx[i] = state[i];
            cnt_nx[i]   = cnt[i];
            case (state[i])
                RELEASED: begin
                    if (sync2[i]) begin
                        state_nx[i] = PRESS_WAIT;
                        cnt_nx[i]   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_nx[i] = RELEASED;
                        cnt_nx[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_nx[i]  = PRESSED;
                        cnt_nx[i]    = '0;
                        press_acc[i] = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2[i]) begin
                        state_nx[i] = RELEASE_WAIT;
                        cnt_nx[i]   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_nx[i] = PRESSED;
                        cnt_nx[i]   = '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        state_nx[i] = RELEASED;
                        cnt_nx[i]   = '0;
                    end else begin
                        cnt_nx[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nx[i] = RELEASED;
                    cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    // A press accepted on this edge can be granted on the same edge.
    always_comb begin
        pend_nx = pending | press_acc;
        grant   = '0;
        if (pend_nx[0]) begin
            grant = 3'b001;
        end else if (pend_nx[1]) begin
            grant = 3'b010;
        end else if (pend_nx[2]) begin
            grant = 3'b100;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            pending  <= '0;
            o_coin   <= 1'b0;
            o_coffee <= 1'b0;
            o_sprite <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            pending  <= pend_nx & ~grant;
            o_coin   <= grant[0];
            o_coffee <= grant[1];
            o_sprite <= grant[2];
            for (int i = 0; i < 3; i++) begin
                state[i] <= state_nx[i];
                cnt[i]   <= cnt_nx[i];
            end
        end
    end

endmodule

// File: tb/tb_vending_input_conditioner.sv
// tb/tb_vending_input_conditioner.sv - self-checking bench for vending_input_conditioner
module tb_vending_input_conditioner;

    localparam int DB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw   = 3'b000;
    logic       o_coin;
    logic       o_coffee;
    logic       o_sprite;
    logic [2:0] out;

    int total = 0;
    int bad   = 0;

    // Reference model: press/release accepted after DB consecutive opposite samples of the
    // synchronized input; accepted presses queue and drain lowest channel first, one per edge.
    bit         m_h1    [3];
    bit         m_h2    [3];
    bit         m_level [3];
    int         m_run   [3];
    bit         m_pend  [3];
    logic [2:0] exp_out = 3'b000;

    vending_input_conditioner #(.DB_CYCLES(DB), .CNT_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_coin_raw   (raw[0]),
        .i_coffee_raw (raw[1]),
        .i_sprite_raw (raw[2]),
        .o_coin       (o_coin),
        .o_coffee     (o_coffee),
        .o_sprite     (o_sprite)
    );

    assign out = {o_sprite, o_coffee, o_coin};

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int c = 0; c < 3; c++) begin
                    m_h1[c] = 0; m_h2[c] = 0; m_level[c] = 0; m_run[c] = 0; m_pend[c] = 0;
                end
                exp_out = 3'b000;
            end else begin
                bit s;
                bit done;
                done = 0;
                exp_out = 3'b000;
                for (int c = 0; c < 3; c++) begin
                    s = m_h2[c];
                    m_h2[c] = m_h1[c];
                    m_h1[c] = raw[c];
                    if (s != m_level[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DB) begin
                            m_level[c] = s;
                            m_run[c] = 0;
                            if (s) m_pend[c] = 1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                for (int c = 0; c < 3; c++) begin
                    if (!done && m_pend[c]) begin
                        exp_out[c] = 1'b1;
                        m_pend[c] = 0;
                        done = 1;
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        raw = 3'b000;
        repeat (3) @(negedge clk);
        total++;
        if (out !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000", out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_coin;
        int n = 0;
        int first = -1;
        for (int i = 0; i < 40; i++) begin
            raw = (i < 20) ? 3'b001 : 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL clean_coin_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            if (out != 3'b000) begin
                n++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (n !== 1 || first !== 5) begin
            bad++;
            $display("FAIL clean_coin_pulse got=%0d@%0d want=1@5", n, first);
        end
    endtask

    task automatic test_coffee_bounce;
        int n = 0;
        int first = -1;
        for (int i = 0; i < 32; i++) begin
            if (i < 4)       raw = (i % 2 == 0) ? 3'b010 : 3'b000;
            else if (i < 14) raw = 3'b010;
            else             raw = 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL coffee_bounce_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            if (o_coffee) begin
                n++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (n !== 1 || first !== 9) begin
            bad++;
            $display("FAIL coffee_bounce_pulse got=%0d@%0d want=1@9", n, first);
        end
    endtask

    task automatic test_sprite_release_bounce;
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < 10)      raw = 3'b100;
            else if (i < 12) raw = 3'b000;
            else if (i < 14) raw = 3'b100;
            else             raw = 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL sprite_bounce_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            if (o_sprite) n++;
        end
        total++;
        if (n !== 1) begin
            bad++;
            $display("FAIL sprite_bounce_count got=%0d want=1", n);
        end
    endtask

    task automatic test_contention;
        int first [3] = '{-1, -1, -1};
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            raw = (i < 10) ? 3'b111 : 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL contention_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            for (int c = 0; c < 3; c++) begin
                if (out[c]) begin
                    n++;
                    if (first[c] < 0) first[c] = i;
                end
            end
        end
        total++;
        if (n !== 3 || first[0] !== 5 || first[1] !== 6 || first[2] !== 7) begin
            bad++;
            $display("FAIL contention_order got=%0d:%0d,%0d,%0d want=3:5,6,7",
                     n, first[0], first[1], first[2]);
        end
    endtask

    task automatic test_reset_mid_press;
        int n = 0;
        int first = -1;
        raw = 3'b001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out != 3'b000) n++;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (out !== 3'b000) begin
                bad++;
                $display("FAIL reset_mid_outputs got=%b want=000", out);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            raw = (i < 15) ? 3'b001 : 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL reset_mid_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            if (out != 3'b000) begin
                n++;
                if (first < 0) first = i;
            end
        end
        total++;
        if (n !== 1 || first !== 5) begin
            bad++;
            $display("FAIL reset_mid_pulse got=%0d@%0d want=1@5", n, first);
        end
    endtask

    task automatic test_glitch;
        int n = 0;
        int first = -1;
        for (int i = 0; i < 36; i++) begin
            if (i < 3)                   raw = 3'b111;
            else if (i >= 16 && i < 26)  raw = 3'b010;
            else                         raw = 3'b000;
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL glitch_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            if (out != 3'b000) begin
                n++;
                if (first < 0) first = i;
            end
        end
        // The follow-up clean coffee press proves the glitch left every channel released.
        total++;
        if (n !== 1 || first !== 21) begin
            bad++;
            $display("FAIL glitch_pulse got=%0d@%0d want=1@21", n, first);
        end
    endtask

    task automatic test_random;
        int hold [3] = '{0, 0, 0};
        int n_dut = 0;
        int n_exp = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    raw[c] = (i >= 760) ? 1'b0 : 1'($urandom_range(0, 1));
                    hold[c] = (i >= 760) ? 40 : int'($urandom_range(1, 12));
                end
                hold[c]--;
            end
            @(negedge clk);
            total++;
            if (out !== exp_out) begin
                bad++;
                $display("FAIL random_cycle%0d got=%b want=%b", i, out, exp_out);
            end
            total++;
            if ($countones(out) > 1) begin
                bad++;
                $display("FAIL random_onehot got=%b want=at-most-one", out);
            end
            n_dut += $countones(out);
            n_exp += $countones(exp_out);
        end
        total++;
        if (n_dut !== n_exp) begin
            bad++;
            $display("FAIL random_pulse_total got=%0d want=%0d", n_dut, n_exp);
        end
    endtask

    initial begin
        test_reset();
        test_clean_coin();
        test_coffee_bounce();
        test_sprite_release_bounce();
        test_contention();
        test_reset_mid_press();
        test_glitch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_input_conditioner.md
# vending_input_conditioner

Front-end conditioner for the vending machine FSM: it takes the three raw, asynchronous, bouncing panel inputs (coin slot switch, coffee button, sprite button) and turns them into clean single-cycle request pulses in the clk domain. Each input is synchronized, debounced with a per-channel press/release state machine, and edge-qualified. A fixed-priority arbiter then guarantees at most one request pulse per cycle. Its outputs drive the FSM's i_coin, i_coffee and i_sprite inputs directly.

## Interface
- DB_CYCLES, 1000000: consecutive stable synchronized samples required to accept a press or a release; legal range 4 to 2^CNT_W−1.
- CNT_W, 20: debounce counter width.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_coin_raw  input  1  raw coin switch, active-high, asynchronous.
- i_coffee_raw  input  1  raw coffee button, active-high, asynchronous.
- i_sprite_raw  input  1  raw sprite button, active-high, asynchronous.
- o_coin  output  1  one-cycle coin request pulse, registered.
- o_coffee  output  1  one-cycle coffee request pulse, registered.
- o_sprite  output  1  one-cycle sprite request pulse, registered.

## Operation
- Per channel: 2-flop synchronizer producing s.
- Per-channel debounce FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT, with a CNT_W-bit counter:
  - RELEASED: s=1 → PRESS_WAIT, cnt=1.
  - PRESS_WAIT: s=0 → RELEASED, cnt=0. s=1 and cnt<DB_CYCLES−1 → cnt+1. s=1 and cnt==DB_CYCLES−1 → PRESSED, cnt=0, set the channel's pending flag.
  - PRESSED: s=0 → RELEASE_WAIT, cnt=1. Otherwise hold.
  - RELEASE_WAIT: s=1 → PRESSED, cnt=0, with no new request. s=0 and cnt==DB_CYCLES−1 → RELEASED, cnt=0. Otherwise cnt+1.
- Exactly one request per accepted press, however long the button is held. A release bounce shorter than DB_CYCLES never creates a second request.
- Arbiter, fixed priority coin > coffee > sprite. On each edge, the highest-priority channel that is pending (or becoming pending on that edge) gets its output register set and its pending flag cleared. Every other output register is cleared. Pending lower-priority requests wait and are issued on later edges, so no request is lost.
- Outputs are mutually exclusive: at most one of o_coin, o_coffee, o_sprite is high in any cycle.
- Counter never wraps; its maximum value is DB_CYCLES−1.

## Timing
- Reset (asynchronous, rst_n=0): synchronizers 0, all FSMs RELEASED, counters 0, pending flags 0, o_coin=o_coffee=o_sprite=0.
- Uncontended latency: the raw input is first captured at edge E0. The output goes high after edge E0+DB_CYCLES+1 and drops after the next edge (pulse width 1 cycle).
- Contention: if k channels qualify on the same edge, they are issued on k consecutive edges in priority order.
- A new press on an already-pending channel is impossible, because release and re-press take at least 2·DB_CYCLES cycles.
- Reset asserted mid-debounce or with a pending request: all state is discarded and no pulse is issued afterwards for that press.
- Input held high across reset deassertion: treated as a fresh press, so exactly one pulse is issued DB_CYCLES+1 edges after the first capture edge following reset release.
- Minimum accepted press or release width: DB_CYCLES cycles of stable s.

## Test plan
(all scenarios run with DB_CYCLES=4)
- Clean coin press held 20 cycles, then released → o_coin high for exactly 1 cycle, 5 edges after first capture; no other outputs; no second pulse on release.
- Coffee bounce: 1-0-1-0 (each 1 cycle), then stable high 10 cycles → exactly one o_coffee pulse, 5 edges after the start of the stable high.
- Release bounce on sprite: held 10 cycles, low 2 cycles, high 2 cycles, then low → exactly one o_sprite pulse total.
- All three raw inputs rise on the same edge → o_coin, o_coffee, o_sprite pulse on three consecutive cycles in that order, never overlapping.
- rst_n pulsed low 2 cycles into PRESS_WAIT of a coin press, input kept high → outputs 0 during reset; exactly one o_coin pulse 5 edges after the first post-reset capture.
- Glitch shorter than DB_CYCLES (3 cycles high) on each input → no output pulse; all FSMs return to RELEASED.
